// File: rtl/opstack_pkg.sv
// Shared types and defaults for the operand stack.
package opstack_pkg;

  typedef logic [31:0] fp_word_t;

  localparam int DEPTH_DEF = 8;
  localparam int PTR_W_DEF = 4;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE,
    OP_DUP
  } stack_op_t;

endpackage

// File: rtl/stack_ptr.sv
// Up/down occupancy counter; up and down together hold. Caller guarantees legal steps.
module stack_ptr
  import opstack_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int PTR_W = PTR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  input  logic             down,
  output logic [PTR_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [PTR_W-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (up && !down)
      count_nxt = count + PTR_W'(1);
    else if (down && !up)
      count_nxt = count - PTR_W'(1);
  end

  // empty/full registered from the next count so they align with count
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == PTR_W'(DEPTH));
    end
  end

endmodule

// File: rtl/operand_stack.sv
// LIFO of floating-point operands with overflow/underflow guarding and sticky errors.
// Optional duplicate-top request enabled by defining OPSTACK_DUP_EN.
module operand_stack
  import opstack_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int PTR_W  = PTR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              clear_err,
`ifdef OPSTACK_DUP_EN
  input  logic              dup,
`endif
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic [DATA_W-1:0] top,
  output logic [PTR_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow_err,
  output logic              underflow_err
);

  localparam int AW = PTR_W - 1;

  logic [DATA_W-1:0] mem [DEPTH];

  stack_op_t         op;
  logic              up, down, wr_en, ovf_evt, udf_evt, pop_fire;
  logic [AW-1:0]     wr_idx;
  logic [DATA_W-1:0] wr_data, top_nxt;
  logic [PTR_W-1:0]  cnt_m1, cnt_m2;

  assign cnt_m1 = count - PTR_W'(1);
  assign cnt_m2 = count - PTR_W'(2);

  always_comb begin
    case ({push, pop})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = OP_REPLACE;
`ifdef OPSTACK_DUP_EN
      default: op = dup ? OP_DUP : OP_NONE;
`else
      default: op = OP_NONE;
`endif
    endcase
  end

  // Only legal steps ever reach the pointer; illegal requests just raise flags
  always_comb begin
    up       = 1'b0;
    down     = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = count[AW-1:0];
    wr_data  = push_data;
    ovf_evt  = 1'b0;
    udf_evt  = 1'b0;
    pop_fire = 1'b0;
    top_nxt  = top;
    case (op)
      OP_PUSH: begin
        if (full) ovf_evt = 1'b1;
        else begin
          up      = 1'b1;
          wr_en   = 1'b1;
          top_nxt = push_data;
        end
      end
      OP_POP: begin
        if (empty) udf_evt = 1'b1;
        else begin
          down     = 1'b1;
          pop_fire = 1'b1;
          top_nxt  = (count == PTR_W'(1)) ? '0 : mem[cnt_m2[AW-1:0]];
        end
      end
      OP_REPLACE: begin
        wr_en   = 1'b1;
        top_nxt = push_data;
        if (empty) begin
          udf_evt = 1'b1;
          up      = 1'b1;
        end else begin
          pop_fire = 1'b1;
          wr_idx   = cnt_m1[AW-1:0];
        end
      end
`ifdef OPSTACK_DUP_EN
      OP_DUP: begin
        if (empty) udf_evt = 1'b1;
        else if (full) ovf_evt = 1'b1;
        else begin
          up      = 1'b1;
          wr_en   = 1'b1;
          wr_data = top;
        end
      end
`endif
      default: ;
    endcase
  end

  stack_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ptr (
    .clk   (clk),
    .rst   (rst),
    .up    (up),
    .down  (down),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // Storage is not reset; stale entries are never visible past count
  always_ff @(posedge clk) begin
    if (!rst && wr_en)
      mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pop_data      <= '0;
      pop_valid     <= 1'b0;
      top           <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      pop_valid <= pop_fire;
      if (pop_fire)
        pop_data <= top;
      top <= top_nxt;
      if (ovf_evt)        overflow_err  <= 1'b1;
      else if (clear_err) overflow_err  <= 1'b0;
      if (udf_evt)        underflow_err <= 1'b1;
      else if (clear_err) underflow_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_stack.sv
// Directed self-checking bench for operand_stack.
module tb_operand_stack;
  import opstack_pkg::*;

  logic        tb_clk = 1'b0;
  logic        rst, push, pop, clear_err, dup;
  fp_word_t    push_data;
  fp_word_t    pop_data, top;
  logic        pop_valid, empty, full, overflow_err, underflow_err;
  logic [3:0]  count;

  int vectors = 0;
  int miscompares = 0;

  always #5 tb_clk = ~tb_clk;

  operand_stack dut (
    .clk           (tb_clk),
    .rst           (rst),
    .push          (push),
    .push_data     (push_data),
    .pop           (pop),
    .clear_err     (clear_err),
`ifdef OPSTACK_DUP_EN
    .dup           (dup),
`endif
    .pop_data      (pop_data),
    .pop_valid     (pop_valid),
    .top           (top),
    .count         (count),
    .empty         (empty),
    .full          (full),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  task automatic step(input logic p, input logic q, input logic c, input fp_word_t d);
    push = p; pop = q; clear_err = c; push_data = d; dup = 1'b0; rst = 1'b0;
    @(posedge tb_clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; push = 1'b0; pop = 1'b0; clear_err = 1'b0; dup = 1'b0; push_data = '0;
    repeat (2) @(posedge tb_clk);
    #1;
    vectors++;
    if ({count, empty, full, top, pop_data, pop_valid, overflow_err, underflow_err}
        !== {4'd0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: count=%0d empty=%b full=%b top=%h pop_data=%h pv=%b ovf=%b udf=%b, required 0 1 0 0 0 0 0 0",
               count, empty, full, top, pop_data, pop_valid, overflow_err, underflow_err);
    end
  endtask

  task automatic test_push();
    fp_word_t v [3] = '{32'h3F800000, 32'h40000000, 32'h40400000};
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, v[i]);
      vectors++;
      if (top !== v[i] || count !== 4'(i + 1)) begin
        miscompares++;
        $display("FAIL push_%0d: top=%h count=%0d, required top=%h count=%0d", i, top, count, v[i], i + 1);
      end
    end
    vectors++;
    if (empty !== 1'b0 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL push3_flags: empty=%b full=%b, required 0 0", empty, full);
    end
  endtask

  task automatic test_pop();
    fp_word_t v [3] = '{32'h40400000, 32'h40000000, 32'h3F800000};
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, '0);
      vectors++;
      if (pop_valid !== 1'b1 || pop_data !== v[i]) begin
        miscompares++;
        $display("FAIL pop_%0d: pop_valid=%b pop_data=%h, required 1 %h", i, pop_valid, pop_data, v[i]);
      end
    end
    step(0, 0, 0, '0);
    vectors++;
    if (pop_valid !== 1'b0 || count !== 4'd0 || empty !== 1'b1 || top !== 32'h0) begin
      miscompares++;
      $display("FAIL pop_done: pv=%b count=%0d empty=%b top=%h, required 0 0 1 0", pop_valid, count, empty, top);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) step(1, 0, 0, 32'h41000000 + i);
    vectors++;
    if (full !== 1'b1 || count !== 4'd8 || top !== 32'h41000007) begin
      miscompares++;
      $display("FAIL fill8: full=%b count=%0d top=%h, required 1 8 41000007", full, count, top);
    end
    step(1, 0, 0, 32'hDEADBEEF);
    vectors++;
    if (count !== 4'd8 || top !== 32'h41000007 || overflow_err !== 1'b1 || full !== 1'b1) begin
      miscompares++;
      $display("FAIL push_full: count=%0d top=%h ovf=%b full=%b, required 8 41000007 1 1", count, top, overflow_err, full);
    end
    step(1, 0, 1, 32'hDEADBEEF);
    vectors++;
    if (overflow_err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_wins_clear: ovf=%b, required 1", overflow_err);
    end
    step(0, 0, 1, '0);
    vectors++;
    if (overflow_err !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_ovf: ovf=%b, required 0", overflow_err);
    end
    step(1, 1, 0, 32'h11111111);
    vectors++;
    if (pop_valid !== 1'b1 || pop_data !== 32'h41000007 || count !== 4'd8 ||
        top !== 32'h11111111 || overflow_err !== 1'b0) begin
      miscompares++;
      $display("FAIL replace_full: pv=%b pd=%h count=%0d top=%h ovf=%b, required 1 41000007 8 11111111 0",
               pop_valid, pop_data, count, top, overflow_err);
    end
    for (int i = 0; i < 8; i++) begin
      fp_word_t exp;
      exp = (i == 0) ? 32'h11111111 : 32'h41000007 - i;
      step(0, 1, 0, '0);
      vectors++;
      if (pop_valid !== 1'b1 || pop_data !== exp || count !== 4'(7 - i)) begin
        miscompares++;
        $display("FAIL drain_%0d: pv=%b pd=%h count=%0d, required 1 %h %0d", i, pop_valid, pop_data, count, exp, 7 - i);
      end
    end
  endtask

  task automatic test_underflow();
    step(0, 1, 0, '0);
    vectors++;
    if (pop_valid !== 1'b0 || pop_data !== 32'h41000000 || underflow_err !== 1'b1 || count !== 4'd0) begin
      miscompares++;
      $display("FAIL pop_empty: pv=%b pd=%h udf=%b count=%0d, required 0 41000000 1 0", pop_valid, pop_data, underflow_err, count);
    end
    step(0, 0, 1, '0);
    vectors++;
    if (underflow_err !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_udf: udf=%b, required 0", underflow_err);
    end
    step(1, 1, 0, 32'hC0000000);
    vectors++;
    if (count !== 4'd1 || top !== 32'hC0000000 || underflow_err !== 1'b1 || pop_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL replace_empty: count=%0d top=%h udf=%b pv=%b, required 1 c0000000 1 0", count, top, underflow_err, pop_valid);
    end
  endtask

  task automatic test_replace();
    step(1, 0, 0, 32'h40A00000);
    step(1, 1, 0, 32'h41200000);
    vectors++;
    if (pop_valid !== 1'b1 || pop_data !== 32'h40A00000 || count !== 4'd2 || top !== 32'h41200000) begin
      miscompares++;
      $display("FAIL replace_2: pv=%b pd=%h count=%0d top=%h, required 1 40a00000 2 41200000", pop_valid, pop_data, count, top);
    end
    step(0, 1, 0, '0);
    vectors++;
    if (pop_data !== 32'h41200000 || top !== 32'hC0000000 || count !== 4'd1) begin
      miscompares++;
      $display("FAIL pop_after_replace: pd=%h top=%h count=%0d, required 41200000 c0000000 1", pop_data, top, count);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 32'h42000000 + i);
    vectors++;
    if (count !== 4'd5) begin
      miscompares++;
      $display("FAIL pre_reset_count: count=%0d, required 5", count);
    end
    rst = 1'b1; push = 1'b1; push_data = 32'h12345678;
    @(posedge tb_clk); #1;
    rst = 1'b0; push = 1'b0;
    vectors++;
    if ({count, empty, full, top, pop_data, pop_valid, overflow_err, underflow_err}
        !== {4'd0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid: count=%0d empty=%b full=%b top=%h pd=%h pv=%b ovf=%b udf=%b, required 0 1 0 0 0 0 0 0",
               count, empty, full, top, pop_data, pop_valid, overflow_err, underflow_err);
    end
  endtask

`ifdef OPSTACK_DUP_EN
  task automatic test_dup();
    step(1, 0, 0, 32'h3F800000);
    dup = 1'b1; @(posedge tb_clk); #1; dup = 1'b0;
    vectors++;
    if (count !== 4'd2 || top !== 32'h3F800000) begin
      miscompares++;
      $display("FAIL dup: count=%0d top=%h, required 2 3f800000", count, top);
    end
    step(0, 1, 0, '0);
    vectors++;
    if (pop_data !== 32'h3F800000 || top !== 32'h3F800000 || count !== 4'd1) begin
      miscompares++;
      $display("FAIL dup_pop: pd=%h top=%h count=%0d, required 3f800000 3f800000 1", pop_data, top, count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_push();
    test_pop();
    test_overflow();
    test_underflow();
    test_replace();
    test_reset_mid();
`ifdef OPSTACK_DUP_EN
    test_dup();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/operand_stack.md
# operand_stack

Push/pop LIFO holding 32-bit floating-point operands for the co-processor's execution unit. Accepts push/pop requests from the command decoder and turns them into legal up/down steps for its internal stack pointer. Guards against overflow and underflow, so no illegal step ever reaches the pointer. Presents the current top-of-stack and the popped operand to the arithmetic datapath.

## Interface
- DATA_W, 32, operand width (IEEE-754 single)
- DEPTH, 8, number of stack entries (power of two)
- PTR_W, 4, pointer/count width; equals log2(DEPTH)+1
- clk  in  1  system clock, rising-edge
- rst  in  1  synchronous, active-high reset
- push  in  1  push request, sampled at posedge
- push_data  in  DATA_W  operand to push
- pop  in  1  pop request, sampled at posedge
- clear_err  in  1  clears sticky error flags
- dup  in  1  duplicate-top request (present only with OPSTACK_DUP_EN)
- pop_data  out  DATA_W  operand removed by the last accepted pop
- pop_valid  out  1  one-cycle pulse: pop_data updated
- top  out  DATA_W  current top-of-stack; 0 when empty
- count  out  PTR_W  entries held, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- overflow_err  out  1  sticky: push dropped while full
- underflow_err  out  1  sticky: pop ignored while empty

## Operation
- The following operations are decoded each cycle from {push, pop}:
  - none: hold.
  - push: write push_data at index count; count+1.
  - pop: pop_data <= mem[count-1]; pop_valid=1; count-1.
  - push+pop (replace): pop_data <= old top; pop_valid=1; the top slot is overwritten with push_data; count unchanged.
- Boundary conditions:
  - push while full (no pop): data dropped, count held, overflow_err set.
  - pop while empty (no push): pop_valid stays 0, pop_data held, underflow_err set.
  - push+pop while empty: the push is performed (count 0->1); the pop is ignored; underflow_err is set.
  - push+pop while full: normal replace; no error.
- The pointer never wraps. count stays within 0..DEPTH in all cases.
- clear_err clears both flags. If an error occurs in the same cycle as clear_err, the error wins and the flag stays set.
- rst overrides every request in the same cycle. Mid-operation reset discards the stack contents logically: count=0. Memory contents are not reset and are never observable.

## Timing
- All outputs are registered and reflect the request sampled at edge N immediately after edge N.
- Pop latency is one cycle: pop_data and pop_valid are valid after the sampling edge. pop_valid is high for exactly one cycle per accepted pop.
- top, count, empty and full update on the same edge as the operation. top equals mem[count-1] after the edge.
- Back-to-back push/pop is accepted every cycle. There is no stall and no ready signal.
- Reset values: count=0, empty=1, full=0, top=0, pop_data=0, pop_valid=0, overflow_err=0, underflow_err=0.

## Configuration
- OPSTACK_DUP_EN defined:
  - The dup port exists.
  - dup with push=pop=0 pushes a copy of top (count+1).
  - dup while full is dropped and sets overflow_err.
  - dup while empty does nothing and sets underflow_err.
  - dup is ignored whenever push or pop is asserted.
- OPSTACK_DUP_EN undefined: no dup port and no duplicate logic; behaviour is otherwise identical.

## Structure
- Package opstack_pkg contains:
  - the fp_word_t typedef (logic [31:0]);
  - the default DEPTH and PTR_W constants;
  - the stack_op_t enum: OP_NONE, OP_PUSH, OP_POP, OP_REPLACE, OP_DUP.
- Sub-module stack_ptr:
  - PTR_W-bit up/down counter with synchronous active-high reset;
  - up/down inputs, with both asserted meaning hold;
  - outputs count, empty and full.
- operand_stack decodes requests into legal up/down steps only. It owns the storage array, the output registers and the error flags.

## Test plan
- Reset, then push 0x3F800000, 0x40000000, 0x40400000 on consecutive cycles -> count=3, top=0x40400000, empty=0, full=0.
- Three consecutive pops after that -> pop_data sequence 0x40400000, 0x40000000, 0x3F800000 with pop_valid high for exactly 3 cycles; count=0, empty=1, top=0.
- Push 8 values, then push once more -> full=1, count=8, top unchanged, overflow_err=1. Then clear_err -> overflow_err=0.
- Pop on empty -> pop_valid=0, underflow_err=1. Push+pop on empty with push_data=0xC0000000 -> count=1, top=0xC0000000, underflow_err=1.
- Push+pop with count=2 and push_data=0x41200000 -> pop_data=old top, pop_valid=1, count=2, top=0x41200000.
- Assert rst with count=5 while push is also asserted -> count=0, empty=1, all outputs at their reset values. With OPSTACK_DUP_EN: dup at count=1 -> count=2, both entries equal.
